// File: rtl/muldiv_seq_pkg.sv
// muldiv_seq_pkg: shared definitions for the mul/div issue controller.
//   - one-hot op bit positions carried on req_op
//   - controller state encoding
//   - divide-by-zero result constants (quotient fill; remainder is the dividend)
package muldiv_seq_pkg;

    localparam int unsigned MD_OP_W      = 4;
    localparam int unsigned MD_OP_MUL_LO = 0;
    localparam int unsigned MD_OP_MOD    = 1;
    localparam int unsigned MD_OP_MUL_HI = 2;
    localparam int unsigned MD_OP_DIV    = 3;

    typedef enum logic [1:0] {
        MD_IDLE,
        MD_ISSUE,
        MD_WAIT,
        MD_DONE
    } md_state_e;

    // Quotient returned for x/0; sliced down to XLEN by the user.
    localparam logic [63:0] MD_DIV0_QUO = '1;

    // A request is only acted on when exactly one op bit is set.
    function automatic logic md_op_legal(input logic [MD_OP_W-1:0] op);
        return $onehot(op);
    endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// muldiv_seq_if: EXE-side request/response bundle of the mul/div controller.
//   req_valid/req_ready  request handshake
//   req_op/req_sign/req_src1/req_src2  one-hot op, signedness, operands
//   flush                cancel from EXE (exception/ertn/stall)
//   resp_valid/resp_ready/resp_data  result handshake
// master = EXE stage, slave = muldiv_seq.
interface muldiv_seq_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic [3:0]      req_op;
    logic            req_sign;
    logic [XLEN-1:0] req_src1;
    logic [XLEN-1:0] req_src2;
    logic            flush;
    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] resp_data;

    modport master (
        output req_valid, req_op, req_sign, req_src1, req_src2, flush, resp_ready,
        input  req_ready, resp_valid, resp_data
    );

    modport slave (
        input  req_valid, req_op, req_sign, req_src1, req_src2, flush, resp_ready,
        output req_ready, resp_valid, resp_data
    );
endinterface

// File: rtl/muldiv_seq_md_result_cache.sv
// md_result_cache: one-entry cache of the last completed divide.
// Ports:
//   clk, reset                      clock, synchronous active-high reset (clears valid)
//   load, load_sign/a/b             write tag {sign,a,b} together with ...
//   load_quo, load_rem              ... both quotient and remainder
//   lookup_sign/a/b                 tag presented by a new request
//   hit, hit_quo, hit_rem           combinational match and stored results
module md_result_cache
    import muldiv_seq_pkg::*;
#(
    parameter bit CACHE_EN = 1'b1,
    parameter int XLEN     = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            load_sign,
    input  logic [XLEN-1:0] load_a,
    input  logic [XLEN-1:0] load_b,
    input  logic [XLEN-1:0] load_quo,
    input  logic [XLEN-1:0] load_rem,
    input  logic            lookup_sign,
    input  logic [XLEN-1:0] lookup_a,
    input  logic [XLEN-1:0] lookup_b,
    output logic            hit,
    output logic [XLEN-1:0] hit_quo,
    output logic [XLEN-1:0] hit_rem
);

    logic            valid_q;
    logic            tag_sign_q;
    logic [XLEN-1:0] tag_a_q;
    logic [XLEN-1:0] tag_b_q;
    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] rem_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q    <= 1'b0;
            tag_sign_q <= 1'b0;
            tag_a_q    <= '0;
            tag_b_q    <= '0;
            quo_q      <= '0;
            rem_q      <= '0;
        end else if (load) begin
            valid_q    <= 1'b1;
            tag_sign_q <= load_sign;
            tag_a_q    <= load_a;
            tag_b_q    <= load_b;
            quo_q      <= load_quo;
            rem_q      <= load_rem;
        end
    end

    always_comb begin
        hit = CACHE_EN && valid_q
              && (tag_sign_q == lookup_sign)
              && (tag_a_q == lookup_a)
              && (tag_b_q == lookup_b);
    end

    assign hit_quo = quo_q;
    assign hit_rem = rem_q;

endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: issue/sequence controller between EXE and the shared MUL and DIV units.
// Accepts one request at a time, registers the operands, pulses the selected unit's
// start, waits for its done, and holds the selected result until EXE takes it.
// Divide-by-zero and repeat div/mod on identical operands complete without the unit.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   exe               EXE request/response/flush bundle (slave side)
//   mul_start         one-cycle start to multiplier
//   mul_done/hi/lo    multiplier completion and result words
//   div_start         one-cycle start to divider
//   div_done/quo/rem  divider completion and results
//   unit_flush        cancel to both units when an in-flight op is flushed
//   op_a/op_b/op_sign registered operands driven to the units
//   busy              controller not idle
module muldiv_seq
    import muldiv_seq_pkg::*;
#(
    parameter bit CACHE_EN = 1'b1,
    parameter int XLEN     = 32
) (
    input  logic              clk,
    input  logic              reset,
    muldiv_seq_if.slave       exe,
    output logic              mul_start,
    input  logic              mul_done,
    input  logic [XLEN-1:0]   mul_hi,
    input  logic [XLEN-1:0]   mul_lo,
    output logic              div_start,
    input  logic              div_done,
    input  logic [XLEN-1:0]   div_quo,
    input  logic [XLEN-1:0]   div_rem,
    output logic              unit_flush,
    output logic [XLEN-1:0]   op_a,
    output logic [XLEN-1:0]   op_b,
    output logic              op_sign,
    output logic              busy
);

    md_state_e            state_q, state_d;
    logic [MD_OP_W-1:0]   op_q;
    logic [XLEN-1:0]      result_q, result_d;
    logic                 result_we;
    logic                 cache_load;
    logic                 cache_hit;
    logic [XLEN-1:0]      cache_quo;
    logic [XLEN-1:0]      cache_rem;

    logic                 accept;
    logic                 req_legal;
    logic                 req_divmod;
    logic                 req_div0;
    logic                 op_is_mul;

    assign exe.req_ready  = (state_q == MD_IDLE) && !exe.flush;
    assign exe.resp_valid = (state_q == MD_DONE);
    assign exe.resp_data  = result_q;
    assign busy           = (state_q != MD_IDLE);

    assign accept     = exe.req_valid && exe.req_ready;
    assign req_legal  = md_op_legal(exe.req_op);
    assign req_divmod = req_legal && (exe.req_op[MD_OP_DIV] || exe.req_op[MD_OP_MOD]);
    assign req_div0   = req_divmod && (exe.req_src2 == '0);
    assign op_is_mul  = op_q[MD_OP_MUL_LO] || op_q[MD_OP_MUL_HI];

    md_result_cache #(
        .CACHE_EN (CACHE_EN),
        .XLEN     (XLEN)
    ) u_cache (
        .clk         (clk),
        .reset       (reset),
        .load        (cache_load),
        .load_sign   (op_sign),
        .load_a      (op_a),
        .load_b      (op_b),
        .load_quo    (div_quo),
        .load_rem    (div_rem),
        .lookup_sign (exe.req_sign),
        .lookup_a    (exe.req_src1),
        .lookup_b    (exe.req_src2),
        .hit         (cache_hit),
        .hit_quo     (cache_quo),
        .hit_rem     (cache_rem)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= MD_IDLE;
            op_q     <= '0;
            op_sign  <= 1'b0;
            op_a     <= '0;
            op_b     <= '0;
            result_q <= '0;
        end else begin
            state_q <= state_d;
            // Illegal ops are latched too; they simply never leave IDLE.
            if (accept) begin
                op_q    <= exe.req_op;
                op_sign <= exe.req_sign;
                op_a    <= exe.req_src1;
                op_b    <= exe.req_src2;
            end
            if (result_we) begin
                result_q <= result_d;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        result_d   = result_q;
        result_we  = 1'b0;
        cache_load = 1'b0;
        mul_start  = 1'b0;
        div_start  = 1'b0;
        unit_flush = 1'b0;

        case (state_q)
            MD_IDLE: begin
                if (accept && req_legal) begin
                    if (req_div0) begin
                        state_d   = MD_DONE;
                        result_we = 1'b1;
                        result_d  = exe.req_op[MD_OP_DIV] ? MD_DIV0_QUO[XLEN-1:0]
                                                          : exe.req_src1;
                    end else if (req_divmod && cache_hit) begin
                        state_d   = MD_DONE;
                        result_we = 1'b1;
                        result_d  = exe.req_op[MD_OP_DIV] ? cache_quo : cache_rem;
                    end else begin
                        state_d = MD_ISSUE;
                    end
                end
            end
            MD_ISSUE: begin
                mul_start = op_is_mul;
                div_start = !op_is_mul;
                state_d   = MD_WAIT;
            end
            MD_WAIT: begin
                if (op_is_mul && mul_done) begin
                    state_d   = MD_DONE;
                    result_we = 1'b1;
                    result_d  = op_q[MD_OP_MUL_HI] ? mul_hi : mul_lo;
                end else if (!op_is_mul && div_done) begin
                    state_d    = MD_DONE;
                    result_we  = 1'b1;
                    result_d   = op_q[MD_OP_DIV] ? div_quo : div_rem;
                    cache_load = 1'b1;
                end
            end
            MD_DONE: begin
                if (exe.resp_ready) begin
                    state_d = MD_IDLE;
                end
            end
            default: state_d = MD_IDLE;
        endcase

        // Flush overrides everything decided above, including a same-cycle done,
        // so a cancelled divide never reaches the cache.
        if (exe.flush) begin
            state_d    = MD_IDLE;
            result_we  = 1'b0;
            cache_load = 1'b0;
            mul_start  = 1'b0;
            div_start  = 1'b0;
            unit_flush = !reset && ((state_q == MD_ISSUE) || (state_q == MD_WAIT));
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
module tb_muldiv_seq;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic            mul_start, mul_done;
    logic [XLEN-1:0] mul_hi, mul_lo;
    logic            div_start, div_done;
    logic [XLEN-1:0] div_quo, div_rem;
    logic            unit_flush;
    logic [XLEN-1:0] op_a, op_b;
    logic            op_sign, busy;

    muldiv_seq_if #(.XLEN(XLEN)) exe ();

    muldiv_seq #(.CACHE_EN(1'b1), .XLEN(XLEN)) dut (
        .clk        (clk),
        .reset      (reset),
        .exe        (exe),
        .mul_start  (mul_start),
        .mul_done   (mul_done),
        .mul_hi     (mul_hi),
        .mul_lo     (mul_lo),
        .div_start  (div_start),
        .div_done   (div_done),
        .div_quo    (div_quo),
        .div_rem    (div_rem),
        .unit_flush (unit_flush),
        .op_a       (op_a),
        .op_b       (op_b),
        .op_sign    (op_sign),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference view of the result cache: the last divide that actually completed.
    logic            c_valid = 1'b0;
    logic            c_sign;
    logic [XLEN-1:0] c_a, c_b;

    localparam logic [3:0] OP_MUL_LO = 4'b0001;
    localparam logic [3:0] OP_MOD    = 4'b0010;
    localparam logic [3:0] OP_MUL_HI = 4'b0100;
    localparam logic [3:0] OP_DIV    = 4'b1000;

    task automatic check_eq(input string tag, input logic [XLEN-1:0] got,
                            input logic [XLEN-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Mathematical results for the operands, independent of any datapath detail.
    task automatic ref_calc(input logic sgn, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                            output logic [XLEN-1:0] hi, output logic [XLEN-1:0] lo,
                            output logic [XLEN-1:0] quo, output logic [XLEN-1:0] rem);
        int          sa, sb;
        longint      p, q, r;
        logic [63:0] pu;
        sa = a;
        sb = b;
        if (sgn) begin
            p  = longint'(sa) * longint'(sb);
            pu = p;
        end else begin
            pu = {32'h0, a} * {32'h0, b};
        end
        hi = pu[63:32];
        lo = pu[31:0];
        if (b == 0) begin
            quo = '1;
            rem = a;
        end else if (sgn) begin
            q   = longint'(sa) / longint'(sb);
            r   = longint'(sa) % longint'(sb);
            quo = q[31:0];
            rem = r[31:0];
        end else begin
            quo = a / b;
            rem = a % b;
        end
    endtask

    task automatic junk_units();
        mul_hi  = $urandom;
        mul_lo  = $urandom;
        div_quo = $urandom;
        div_rem = $urandom;
    endtask

    task automatic start_req(input logic [3:0] op, input logic sgn,
                             input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        exe.req_valid = 1'b1;
        exe.req_op    = op;
        exe.req_sign  = sgn;
        exe.req_src1  = a;
        exe.req_src2  = b;
        tick();
        exe.req_valid = 1'b0;
        exe.req_src1  = $urandom;
        exe.req_src2  = $urandom;
    endtask

    // Full transaction: accept, optional unit round trip, back-pressure, retire.
    task automatic do_op(input logic [3:0] op, input logic sgn, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, input int lat, input int hold);
        logic            legal, divmod, ismul, short_path;
        logic [XLEN-1:0] hi, lo, quo, rem, exp;
        legal  = $onehot(op);
        divmod = legal && (op[1] || op[3]);
        ismul  = legal && (op[0] || op[2]);
        ref_calc(sgn, a, b, hi, lo, quo, rem);
        exp = op[0] ? lo : op[2] ? hi : op[3] ? quo : rem;
        short_path = divmod && (b == 0 || (c_valid && c_sign == sgn && c_a == a && c_b == b));

        check_eq("req_ready_idle", 32'(exe.req_ready), 32'd1);
        start_req(op, sgn, a, b);
        check_eq("op_a", op_a, a);
        check_eq("op_b", op_b, b);
        check_eq("op_sign", 32'(op_sign), 32'(sgn));

        if (!legal) begin
            check_eq("illegal_busy", 32'(busy), 32'd0);
            check_eq("illegal_resp_valid", 32'(exe.resp_valid), 32'd0);
            check_eq("illegal_starts", {30'd0, mul_start, div_start}, 32'd0);
            return;
        end

        if (short_path) begin
            check_eq("short_resp_valid", 32'(exe.resp_valid), 32'd1);
            check_eq("short_no_start", {30'd0, mul_start, div_start}, 32'd0);
        end else begin
            check_eq("issue_resp_valid", 32'(exe.resp_valid), 32'd0);
            check_eq("issue_mul_start", 32'(mul_start), 32'(ismul));
            check_eq("issue_div_start", 32'(div_start), 32'(divmod));
            tick();
            check_eq("wait_starts_low", {30'd0, mul_start, div_start}, 32'd0);
            for (int i = 0; i < lat; i++) begin
                if ($urandom_range(0, 1) == 1) begin
                    mul_done = divmod;
                    div_done = ismul;
                end
                tick();
                mul_done = 1'b0;
                div_done = 1'b0;
                check_eq("wait_resp_valid", 32'(exe.resp_valid), 32'd0);
                check_eq("wait_busy", 32'(busy), 32'd1);
            end
            mul_hi  = hi;
            mul_lo  = lo;
            div_quo = quo;
            div_rem = rem;
            mul_done = ismul;
            div_done = divmod;
            tick();
            mul_done = 1'b0;
            div_done = 1'b0;
            junk_units();
            check_eq("done_resp_valid", 32'(exe.resp_valid), 32'd1);
            if (divmod) begin
                c_valid = 1'b1;
                c_sign  = sgn;
                c_a     = a;
                c_b     = b;
            end
        end
        check_eq("resp_data", exe.resp_data, exp);

        for (int h = 0; h < hold; h++) begin
            mul_done = $urandom_range(0, 1) == 1;
            div_done = $urandom_range(0, 1) == 1;
            tick();
            mul_done = 1'b0;
            div_done = 1'b0;
            check_eq("hold_resp_valid", 32'(exe.resp_valid), 32'd1);
            check_eq("hold_resp_data", exe.resp_data, exp);
        end

        exe.resp_ready = 1'b1;
        tick();
        exe.resp_ready = 1'b0;
        check_eq("retire_resp_valid", 32'(exe.resp_valid), 32'd0);
        check_eq("retire_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [3:0]      op;
        logic            sgn, psgn;
        logic [XLEN-1:0] a, b, pa, pb;

        reset          = 1'b1;
        exe.req_valid  = 1'b0;
        exe.req_op     = '0;
        exe.req_sign   = 1'b0;
        exe.req_src1   = '0;
        exe.req_src2   = '0;
        exe.flush      = 1'b0;
        exe.resp_ready = 1'b0;
        mul_done       = 1'b0;
        div_done       = 1'b0;
        junk_units();
        tick();
        tick();
        check_eq("rst_resp_valid", 32'(exe.resp_valid), 32'd0);
        check_eq("rst_resp_data", exe.resp_data, 32'd0);
        check_eq("rst_starts", {30'd0, mul_start, div_start}, 32'd0);
        check_eq("rst_unit_flush", 32'(unit_flush), 32'd0);
        check_eq("rst_op_a", op_a, 32'd0);
        check_eq("rst_op_b", op_b, 32'd0);
        check_eq("rst_op_sign", 32'(op_sign), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        tick();

        // signed 7 * -3, three cycles of back-pressure
        do_op(OP_MUL_LO, 1'b1, 32'd7, -32'sd3, 2, 3);
        check_eq("mul_lo_neg21", exe.resp_data, 32'hFFFF_FFEB);
        // div then mod on the same operands: second completes from the cache
        do_op(OP_DIV, 1'b0, 32'd100, 32'd7, 1, 0);
        check_eq("div_100_7", exe.resp_data, 32'd14);
        do_op(OP_MOD, 1'b0, 32'd100, 32'd7, 0, 1);
        check_eq("mod_100_7", exe.resp_data, 32'd2);
        // divide by zero
        do_op(OP_DIV, 1'b0, 32'd5, 32'd0, 0, 0);
        check_eq("div_5_0", exe.resp_data, 32'hFFFF_FFFF);
        do_op(OP_MOD, 1'b1, 32'd5, 32'd0, 0, 0);
        check_eq("mod_5_0", exe.resp_data, 32'd5);

        // flush while waiting on the divider
        start_req(OP_DIV, 1'b0, 32'd1000, 32'd3);
        check_eq("fw_div_start", 32'(div_start), 32'd1);
        tick();
        exe.flush = 1'b1;
        #1;
        check_eq("fw_unit_flush", 32'(unit_flush), 32'd1);
        check_eq("fw_req_ready", 32'(exe.req_ready), 32'd0);
        div_quo  = 32'd333;
        div_rem  = 32'd1;
        div_done = 1'b1;
        tick();
        exe.flush = 1'b0;
        div_done  = 1'b0;
        #1;
        check_eq("fw_unit_flush_1cyc", 32'(unit_flush), 32'd0);
        check_eq("fw_busy", 32'(busy), 32'd0);
        check_eq("fw_resp_valid", 32'(exe.resp_valid), 32'd0);
        div_done = 1'b1;
        tick();
        div_done = 1'b0;
        check_eq("fw_idle_done_ignored", 32'(exe.resp_valid), 32'd0);
        do_op(OP_MOD, 1'b0, 32'd1000, 32'd3, 2, 0);
        check_eq("mod_1000_3", exe.resp_data, 32'd1);

        // flush together with resp_ready in DONE
        start_req(OP_DIV, 1'b0, 32'd1000, 32'd3);
        check_eq("fd_hit_valid", 32'(exe.resp_valid), 32'd1);
        check_eq("fd_hit_no_start", 32'(div_start), 32'd0);
        check_eq("fd_hit_data", exe.resp_data, 32'd333);
        exe.flush      = 1'b1;
        exe.resp_ready = 1'b1;
        #1;
        check_eq("fd_no_unit_flush", 32'(unit_flush), 32'd0);
        tick();
        exe.flush      = 1'b0;
        exe.resp_ready = 1'b0;
        #1;
        check_eq("fd_resp_valid", 32'(exe.resp_valid), 32'd0);
        check_eq("fd_busy", 32'(busy), 32'd0);
        tick();
        check_eq("fd_no_dup", 32'(exe.resp_valid), 32'd0);

        // flush in ISSUE suppresses the start pulse
        start_req(OP_MUL_HI, 1'b1, 32'd12345, 32'd678);
        exe.flush = 1'b1;
        #1;
        check_eq("fi_mul_start", 32'(mul_start), 32'd0);
        check_eq("fi_unit_flush", 32'(unit_flush), 32'd1);
        tick();
        exe.flush = 1'b0;
        #1;
        check_eq("fi_busy", 32'(busy), 32'd0);

        // flush blocks acceptance in IDLE
        exe.flush     = 1'b1;
        exe.req_valid = 1'b1;
        exe.req_op    = OP_MUL_LO;
        #1;
        check_eq("fa_req_ready", 32'(exe.req_ready), 32'd0);
        tick();
        exe.flush     = 1'b0;
        exe.req_valid = 1'b0;
        #1;
        check_eq("fa_busy", 32'(busy), 32'd0);

        // reset mid-operation clears outputs and the cache
        do_op(OP_DIV, 1'b1, -32'sd77, 32'd5, 0, 0);
        start_req(OP_MUL_LO, 1'b0, 32'd3, 32'd4);
        tick();
        reset = 1'b1;
        #1;
        check_eq("rw_unit_flush", 32'(unit_flush), 32'd0);
        tick();
        reset = 1'b0;
        #1;
        check_eq("rw_resp_valid", 32'(exe.resp_valid), 32'd0);
        check_eq("rw_resp_data", exe.resp_data, 32'd0);
        check_eq("rw_op_a", op_a, 32'd0);
        check_eq("rw_op_b", op_b, 32'd0);
        check_eq("rw_busy", 32'(busy), 32'd0);
        check_eq("rw_starts", {30'd0, mul_start, div_start}, 32'd0);
        c_valid = 1'b0;
        do_op(OP_DIV, 1'b1, -32'sd77, 32'd5, 1, 0);
        check_eq("div_m77_5", exe.resp_data, -32'sd15);

        // signed overflow and unsigned high word
        do_op(OP_DIV, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        check_eq("div_ovf", exe.resp_data, 32'h8000_0000);
        do_op(OP_MOD, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        check_eq("mod_ovf", exe.resp_data, 32'd0);
        do_op(OP_MUL_HI, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        check_eq("mulhu_max", exe.resp_data, 32'hFFFF_FFFE);

        // randomized traffic
        pa = 32'd9; pb = 32'd4; psgn = 1'b0;
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 15) == 0) begin
                op = 4'($urandom_range(0, 15));
                if ($onehot(op)) op = 4'b0110;
            end else begin
                op = 4'b0001 << $urandom_range(0, 3);
            end
            sgn = 1'($urandom_range(0, 1));
            a   = $urandom;
            b   = $urandom;
            case ($urandom_range(0, 7))
                0: b = '0;
                1: begin a = 32'h8000_0000; b = '1; end
                2: begin a = 32'($urandom_range(0, 50)); b = 32'($urandom_range(1, 9)); end
                3, 4: begin a = pa; b = pb; sgn = psgn; end
                default: ;
            endcase
            do_op(op, sgn, a, b, $urandom_range(0, 3), $urandom_range(0, 3));
            pa = a; pb = b; psgn = sgn;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
